// File: rtl/sampler_dma_csr_bank.sv
// sampler_dma_csr_bank
// Register bank between the AXI-Lite slave and the per-voice sampler DMA engines.
// A global window of NUM_OF_CONTROL_REG words comes first. After it, each voice
// has a window of 8 words: base address, length, control, status, current
// address, IRQ status, IRQ mask, and one reserved or done-count slot.
//
// Optional feature (macro SAMPLER_DMA_DONE_COUNT_EN): voice slot 7 becomes a
// 16-bit saturating dma_done counter. Any write to slot 7 with byte_enable[0]
// clears it.
//
// Ports:
//   axi_clk, axi_reset             clock, asynchronous active-low reset
//   data_in, byte_enable           write data and byte strobes
//   reg_addr_wr, data_wren         write word address and one-cycle write strobe
//   reg_addr_rd, data_out          read word address, combinational read data
//   dma_base_addr, dma_length      per-voice configuration
//   dma_loop, dma_start, dma_stop  per-voice loop enable and one-cycle commands
//   dma_status, dma_curr_addr      engine state, registered before readback
//   dma_done, dma_error            one-cycle engine events
//   irq                            registered interrupt
module sampler_dma_csr_bank #(
    parameter int MAX_VOICES         = 8,
    parameter int OPT_MEM_ADDR_BITS  = 10,
    parameter int NUM_OF_CONTROL_REG = 16,
    parameter int REGS_PER_VOICE     = 8
) (
    input  logic                                axi_clk,
    input  logic                                axi_reset,
    input  logic [31:0]                         data_in,
    output logic [31:0]                         data_out,
    input  logic [OPT_MEM_ADDR_BITS-1:0]        reg_addr_wr,
    input  logic [OPT_MEM_ADDR_BITS-1:0]        reg_addr_rd,
    input  logic                                data_wren,
    input  logic [3:0]                          byte_enable,
    output logic [MAX_VOICES-1:0][31:0]         dma_base_addr,
    output logic [MAX_VOICES-1:0][31:0]         dma_length,
    output logic [MAX_VOICES-1:0]               dma_loop,
    output logic [MAX_VOICES-1:0]               dma_start,
    output logic [MAX_VOICES-1:0]               dma_stop,
    input  logic [MAX_VOICES-1:0][31:0]         dma_status,
    input  logic [MAX_VOICES-1:0][31:0]         dma_curr_addr,
    input  logic [MAX_VOICES-1:0]               dma_done,
    input  logic [MAX_VOICES-1:0]               dma_error,
    output logic                                irq
);

    localparam logic [31:0] VOICE_LO = 32'(NUM_OF_CONTROL_REG);
    localparam logic [31:0] VOICE_HI = 32'(NUM_OF_CONTROL_REG + 8 * MAX_VOICES);

    logic [31:0]                   wa32, ra32, wr_voice, rd_voice;
    logic                          wr_global, wr_in_voice;
    logic [MAX_VOICES-1:0]         wr_hit;
    logic                          global_irq_en;
    logic [31:0]                   scratch;
    logic [MAX_VOICES-1:0][31:0]   status_q, curr_q;
    logic [MAX_VOICES-1:0][1:0]    irq_status, irq_mask, irq_status_nxt;
    logic [MAX_VOICES-1:0]         irq_pending;
`ifdef SAMPLER_DMA_DONE_COUNT_EN
    logic [MAX_VOICES-1:0][15:0]   done_count;
`endif

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    // Write decode; the voice window is 8-aligned, so the slot is the low address bits.
    always_comb begin
        wa32        = 32'(reg_addr_wr);
        wr_voice    = (wa32 - VOICE_LO) >> 3;
        wr_global   = data_wren && (wa32 < VOICE_LO);
        wr_in_voice = data_wren && (wa32 >= VOICE_LO) && (wa32 < VOICE_HI);
        wr_hit      = '0;
        for (int v = 0; v < MAX_VOICES; v++)
            wr_hit[v] = wr_in_voice && (wr_voice == 32'(v));
    end

    // The set term is applied after the clear term, so a done/error event
    // in the same cycle as a W1C write leaves the bit set.
    always_comb begin
        irq_status_nxt = '0;
        irq_pending    = '0;
        for (int v = 0; v < MAX_VOICES; v++) begin
            irq_status_nxt[v] = irq_status[v]
                & ~((wr_hit[v] && reg_addr_wr[2:0] == 3'd5 && byte_enable[0]) ? data_in[1:0] : 2'b00)
                | {dma_error[v], dma_done[v]};
            irq_pending[v] = |(irq_status[v] & irq_mask[v]);
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset) begin
        if (!axi_reset) begin
            global_irq_en <= 1'b0;
            scratch       <= '0;
            dma_base_addr <= '0;
            dma_length    <= '0;
            dma_loop      <= '0;
            dma_start     <= '0;
            dma_stop      <= '0;
            status_q      <= '0;
            curr_q        <= '0;
            irq_status    <= '0;
            irq_mask      <= '0;
            irq           <= 1'b0;
`ifdef SAMPLER_DMA_DONE_COUNT_EN
            done_count    <= '0;
`endif
        end else begin
            if (wr_global && wa32 == 32'd4 && byte_enable[0])
                global_irq_en <= data_in[0];
            if (wr_global && wa32 == 32'd6)
                scratch <= be_merge(scratch, data_in, byte_enable);

            dma_start  <= '0;
            dma_stop   <= '0;
            status_q   <= dma_status;
            curr_q     <= dma_curr_addr;
            irq_status <= irq_status_nxt;
            irq        <= global_irq_en & (|irq_pending);

            for (int v = 0; v < MAX_VOICES; v++) begin
                if (wr_hit[v]) begin
                    case (reg_addr_wr[2:0])
                        3'd0: dma_base_addr[v] <= be_merge(dma_base_addr[v], data_in, byte_enable);
                        3'd1: dma_length[v]    <= be_merge(dma_length[v], data_in, byte_enable);
                        3'd2: if (byte_enable[0]) begin
                            // STOP wins over START when both are written together.
                            dma_start[v] <= data_in[0] & ~data_in[1];
                            dma_stop[v]  <= data_in[1];
                            dma_loop[v]  <= data_in[2];
                        end
                        3'd6: if (byte_enable[0]) irq_mask[v] <= data_in[1:0];
                        default: ;
                    endcase
                end
`ifdef SAMPLER_DMA_DONE_COUNT_EN
                if (wr_hit[v] && reg_addr_wr[2:0] == 3'd7 && byte_enable[0])
                    done_count[v] <= '0;
                else if (dma_done[v] && done_count[v] != 16'hffff)
                    done_count[v] <= done_count[v] + 16'd1;
`endif
            end
        end
    end

    always_comb begin
        ra32     = 32'(reg_addr_rd);
        rd_voice = (ra32 - VOICE_LO) >> 3;
        data_out = 32'hdeaddead;
        if (ra32 < VOICE_LO) begin
            case (ra32)
                32'd0:   data_out = 32'h0000_0002;
                32'd1:   data_out = 32'(MAX_VOICES);
                32'd2:   data_out = 32'(NUM_OF_CONTROL_REG);
                32'd3:   data_out = 32'(REGS_PER_VOICE);
                32'd4:   data_out = {31'b0, global_irq_en};
                32'd5:   data_out = 32'(irq_pending);
                32'd6:   data_out = scratch;
                default: data_out = 32'hbeefdead;
            endcase
        end else if (ra32 < VOICE_HI) begin
            data_out = '0;
            for (int v = 0; v < MAX_VOICES; v++) begin
                if (rd_voice == 32'(v)) begin
                    case (reg_addr_rd[2:0])
                        3'd0:    data_out = dma_base_addr[v];
                        3'd1:    data_out = dma_length[v];
                        3'd2:    data_out = {29'b0, dma_loop[v], 2'b00};
                        3'd3:    data_out = status_q[v];
                        3'd4:    data_out = curr_q[v];
                        3'd5:    data_out = {30'b0, irq_status[v]};
                        3'd6:    data_out = {30'b0, irq_mask[v]};
`ifdef SAMPLER_DMA_DONE_COUNT_EN
                        3'd7:    data_out = {16'b0, done_count[v]};
`endif
                        default: data_out = '0;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/sampler_dma_csr_bank.md
Name: sampler_dma_csr_bank

Overview:
Parametrised second-generation register bank for the sampler DMA unit. It sits between the AXI-Lite slave and the per-voice DMA engines. Over the first generation it adds:
- a per-voice LENGTH register
- self-clearing start/stop command pulses
- byte-enable-honouring writes
- per-voice sticky write-1-to-clear interrupt status with masking
- a single registered interrupt output

Parameters:
MAX_VOICES, 8, number of DMA voices (1..32).
OPT_MEM_ADDR_BITS, 10, register (word) address width.
NUM_OF_CONTROL_REG, 16, global register count; DMA window starts here; multiple of 8.
REGS_PER_VOICE, 8, fixed register stride per voice (power of two, must be 8).

Ports:
axi_clk  in  1  clock
axi_reset  in  1  asynchronous active-low reset
data_in  in  32  write data
data_out  out  32  read data (combinational from reg_addr_rd)
reg_addr_wr  in  OPT_MEM_ADDR_BITS  write word address
reg_addr_rd  in  OPT_MEM_ADDR_BITS  read word address
data_wren  in  1  write strobe, one cycle per write
byte_enable  in  4  byte strobes for data_in
dma_base_addr  out  32 x MAX_VOICES  per-voice base address
dma_length  out  32 x MAX_VOICES  per-voice transfer length in bytes
dma_loop  out  MAX_VOICES  per-voice loop enable
dma_start  out  MAX_VOICES  one-cycle start pulse
dma_stop  out  MAX_VOICES  one-cycle stop pulse
dma_status  in  32 x MAX_VOICES  engine status
dma_curr_addr  in  32 x MAX_VOICES  engine current address
dma_done  in  MAX_VOICES  one-cycle done event
dma_error  in  MAX_VOICES  one-cycle error event
irq  out  1  interrupt, registered

Behaviour:
- Single clock axi_clk. Reset is asynchronous and active-low on axi_reset.
- All outputs and registers reset to 0 (irq=0, pulses=0).
- Address decode:
  - addr < NUM_OF_CONTROL_REG: global.
  - NUM_OF_CONTROL_REG <= addr < NUM_OF_CONTROL_REG + 8*MAX_VOICES: voice v = (addr-NUM_OF_CONTROL_REG)>>3, slot = addr[2:0].
  - Otherwise: read 32'hdeaddead, writes ignored.
- Global map:
  - 0 VERSION RO 32'h0000_0002
  - 1 MAX_VOICES RO
  - 2 NUM_OF_CONTROL_REG RO
  - 3 REGS_PER_VOICE RO
  - 4 GLOBAL_CTRL RW, bit0 = global irq enable
  - 5 IRQ_PENDING RO, bit v = voice v has (IRQ_STATUS & IRQ_MASK) != 0
  - 6 SCRATCH RW 32b
  - Others read 32'hbeefdead, writes ignored.
- Voice slots:
  - 0 BASE_ADDR RW
  - 1 LENGTH RW
  - 2 CONTROL: bit0 START (write-1 pulse, reads 0), bit1 STOP (write-1 pulse, reads 0), bit2 LOOP (RW); other bits read 0
  - 3 STATUS RO
  - 4 CURR_ADDR RO
  - 5 IRQ_STATUS W1C: bit0 done, bit1 error
  - 6 IRQ_MASK RW bits[1:0]
  - 7 reserved, reads 0
- RW writes apply only to bytes whose byte_enable bit is set. START/STOP/LOOP/W1C need byte_enable[0].
- Writes to RO or reserved slots are ignored.
- dma_start[v] / dma_stop[v]: asserted exactly one cycle, the cycle after the write. START and STOP written together: STOP only.
- STATUS and CURR_ADDR are registered copies of the inputs (1-cycle lag). Reads return the registered copy.
- IRQ_STATUS bit is set on a dma_done/dma_error pulse and cleared by writing 1. A simultaneous set and clear results in set.
- irq is registered: irq <= GLOBAL_CTRL[0] & |IRQ_PENDING. Latency is 1 cycle from the status or mask change.
- Reads never have side effects.

Optional Feature:
SAMPLER_DMA_DONE_COUNT_EN:
- Defined: voice slot 7 is DONE_COUNT, a 16-bit counter in [15:0], upper bits 0.
  - Increments on each dma_done pulse and saturates at 16'hFFFF.
  - Any write to slot 7 with byte_enable[0] clears it. A simultaneous increment and clear results in 0.
  - Resets to 0.
- Undefined: slot 7 reads 0 and no counter logic is present.

Test Plan:
- After reset, read addr 0/1/3 -> 32'h0000_0002 / 8 / 8. Read addr 16+8*8=80 -> 32'hdeaddead. Read addr 9 -> 32'hbeefdead.
- Write voice 2 BASE_ADDR (addr 32) = 32'h1234_5678 with byte_enable=4'b0101 over the prior value 0 -> dma_base_addr[2] = 32'h0034_0078 and the readback matches.
- Write voice 0 CONTROL = 32'h5 -> dma_start[0] high for exactly one cycle, dma_loop[0]=1, and the readback is 32'h4. Writing 32'h3 -> only dma_stop[0] pulses.
- Set voice 3 IRQ_MASK=1 and GLOBAL_CTRL=1, then pulse dma_done[3] -> IRQ_STATUS=1, IRQ_PENDING=32'h8, irq=1 one cycle later. Write IRQ_STATUS=1 -> irq=0. Repeating the W1C write in the same cycle as dma_done keeps the bit at 1.
- Pulse dma_error[1] with IRQ_MASK[1]=0 -> IRQ_STATUS[1]=1 and irq stays 0. Setting the mask -> irq=1 after one cycle.
- With SAMPLER_DMA_DONE_COUNT_EN: 3 dma_done[4] pulses -> slot 7 reads 3. Writing slot 7 -> reads 0. Assert axi_reset low mid-sequence -> all counters, pulses and irq are 0 immediately.
